// File: rtl/branch_resolve_unit.sv
// Branch resolution for the decode stage: evaluates signed branch conditions,
// computes the target and holds the branch in WAIT until its operands arrive.
module branch_resolve_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 7,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     valid_in,
    input  logic [2:0]               br_op,
    input  logic signed [DATA_W-1:0] rs_val,
    input  logic signed [DATA_W-1:0] rt_val,
    input  logic                     rs_ready,
    input  logic                     rt_ready,
    input  logic [ADDR_W-1:0]        pc_plus4,
    input  logic [15:0]              imm,
    input  logic                     flush,
    output logic                     stall_out,
    output logic                     resolve_valid,
    output logic                     taken,
    output logic [ADDR_W-1:0]        target,
    output logic                     timeout_err,
    output logic [CNT_W-1:0]         taken_cnt,
    output logic                     busy
);

    localparam logic [2:0] OP_BEQ  = 3'b001;
    localparam logic [2:0] OP_BNE  = 3'b010;
    localparam logic [2:0] OP_BGTZ = 3'b011;
    localparam logic [2:0] OP_BLEZ = 3'b100;
    localparam logic [2:0] OP_BLTZ = 3'b101;
    localparam logic [2:0] OP_BGEZ = 3'b110;
    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state, state_nx;
    logic [7:0] wait_cnt;

    // Branch fields captured on entry to WAIT
    logic [2:0]        op_p0;
    logic [ADDR_W-1:0] pc_p0;
    logic [15:0]       imm_p0;

    logic [2:0]        op_sel;
    logic [ADDR_W-1:0] pc_sel;
    logic [15:0]       imm_sel;
    logic              ops_ready, req_idle, active;
    logic              do_resolve, do_capture, do_timeout;
    logic              cond_sel;
    logic [ADDR_W-1:0] target_sel;

    function automatic logic legal_op(input logic [2:0] op);
        return (op != 3'b000) && (op != 3'b111);
    endfunction

    function automatic logic needs_rt(input logic [2:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

    // Sign tests use the MSB directly so the comparison is unambiguously signed
    function automatic logic eval_cond(input logic [2:0] op,
                                       input logic signed [DATA_W-1:0] a,
                                       input logic signed [DATA_W-1:0] b);
        logic neg, zero;
        neg  = a[DATA_W-1];
        zero = (a == b) && (op == OP_BEQ || op == OP_BNE) ? 1'b0 : (a == '0);
        case (op)
            OP_BEQ:  return a == b;
            OP_BNE:  return a != b;
            OP_BGTZ: return !neg && !zero;
            OP_BLEZ: return neg || zero;
            OP_BLTZ: return neg;
            OP_BGEZ: return !neg;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] calc_target(input logic [ADDR_W-1:0] pc,
                                                      input logic [15:0] offs);
        logic signed [ADDR_W-1:0] ext;
        ext = ADDR_W'($signed(offs));
        return pc + (ext << 2);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + CNT_W'(1);
    endfunction

    always_comb begin
        op_sel     = (state == WAIT) ? op_p0  : br_op;
        pc_sel     = (state == WAIT) ? pc_p0  : pc_plus4;
        imm_sel    = (state == WAIT) ? imm_p0 : imm;
        ops_ready  = rs_ready && (rt_ready || !needs_rt(op_sel));
        req_idle   = (state == IDLE) && valid_in && legal_op(br_op);
        active     = req_idle || (state == WAIT);
        do_resolve = !flush && active && ops_ready;
        do_capture = !flush && req_idle && !ops_ready;
        // Ready wins over an expiring counter
        do_timeout = !flush && (state == WAIT) && !ops_ready && (wait_cnt == WAIT_LIMIT);
        cond_sel   = eval_cond(op_sel, rs_val, rt_val);
        target_sel = calc_target(pc_sel, imm_sel);
        stall_out  = reset && !flush && active && !ops_ready;
        busy       = (state == WAIT);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (do_capture) state_nx = WAIT;
            WAIT: if (flush || ops_ready || do_timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            resolve_valid <= 1'b0;
            taken         <= 1'b0;
            target        <= '0;
            timeout_err   <= 1'b0;
            taken_cnt     <= '0;
        end else begin
            state         <= state_nx;
            resolve_valid <= do_resolve;
            timeout_err   <= do_timeout;
            if (flush || do_capture)
                wait_cnt <= '0;
            else if ((state == WAIT) && !ops_ready && !do_timeout)
                wait_cnt <= wait_cnt + 8'd1;
            if (do_resolve) begin
                taken  <= cond_sel;
                target <= target_sel;
                if (cond_sel)
                    taken_cnt <= sat_inc(taken_cnt);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_capture) begin
            op_p0  <= br_op;
            pc_p0  <= pc_plus4;
            imm_p0 <= imm;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a pending-branch reference model.
module tb_branch_resolve_unit;

    localparam int MW   = 3;
    localparam int CW   = 2;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic valid_in = 1'b0;
    logic [2:0] br_op = 3'b000;
    logic signed [31:0] rs_val = '0;
    logic signed [31:0] rt_val = '0;
    logic rs_ready = 1'b0;
    logic rt_ready = 1'b0;
    logic [31:0] pc_plus4 = '0;
    logic [15:0] imm = '0;
    logic flush = 1'b0;
    logic stall_out, resolve_valid, taken, timeout_err, busy;
    logic [31:0] target;
    logic [CW-1:0] taken_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    branch_resolve_unit #(.DATA_W(32), .ADDR_W(32), .MAX_WAIT(MW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .br_op(br_op),
        .rs_val(rs_val), .rt_val(rt_val), .rs_ready(rs_ready), .rt_ready(rt_ready),
        .pc_plus4(pc_plus4), .imm(imm), .flush(flush), .stall_out(stall_out),
        .resolve_valid(resolve_valid), .taken(taken), .target(target),
        .timeout_err(timeout_err), .taken_cnt(taken_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a branch is either resolved at once or parked as pending
    bit        m_pend = 0;
    bit [2:0]  m_op = 0;
    bit [31:0] m_pc = 0;
    bit [15:0] m_imm = 0;
    int        m_age = 0;
    bit        m_rv = 0, m_tk = 0, m_to = 0;
    bit [31:0] m_tg = 0;
    int        m_cnt = 0;

    function automatic bit m_legal(input bit [2:0] op);
        return op >= 1 && op <= 6;
    endfunction

    function automatic bit m_rdy(input bit [2:0] op);
        return rs_ready && ((op == 1 || op == 2) ? rt_ready : 1'b1);
    endfunction

    function automatic bit m_cond(input bit [2:0] op, input int a, input int b);
        case (op)
            1: return a == b;
            2: return a != b;
            3: return a > 0;
            4: return a <= 0;
            5: return a < 0;
            6: return a >= 0;
            default: return 0;
        endcase
    endfunction

    function automatic bit [31:0] m_tgt(input bit [31:0] pc, input bit [15:0] im);
        int off;
        off = int'($signed(im)) * 4;
        return pc + 32'(off);
    endfunction

    task automatic m_resolve(input bit [2:0] op, input bit [31:0] pc, input bit [15:0] im);
        m_rv = 1;
        m_tk = m_cond(op, rs_val, rt_val);
        m_tg = m_tgt(pc, im);
        if (m_tk && m_cnt < CMAX) m_cnt++;
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pend = 0; m_age = 0; m_rv = 0; m_tk = 0; m_to = 0; m_tg = 0; m_cnt = 0;
        end else begin
            m_rv = 0;
            m_to = 0;
            if (flush) begin
                m_pend = 0;
            end else if (!m_pend) begin
                if (valid_in && m_legal(br_op)) begin
                    if (m_rdy(br_op)) m_resolve(br_op, pc_plus4, imm);
                    else begin
                        m_pend = 1; m_op = br_op; m_pc = pc_plus4; m_imm = imm; m_age = 0;
                    end
                end
            end else if (m_rdy(m_op)) begin
                m_resolve(m_op, m_pc, m_imm);
                m_pend = 0;
            end else if (m_age >= MW) begin
                m_to = 1;
                m_pend = 0;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            bit exp_stall;
            exp_stall = reset && !flush &&
                        (m_pend ? !m_rdy(m_op) : (valid_in && m_legal(br_op) && !m_rdy(br_op)));
            chk("m_resolve_valid", resolve_valid, m_rv);
            chk("m_taken", taken, m_tk);
            chk("m_target", target, m_tg);
            chk("m_timeout_err", timeout_err, m_to);
            chk("m_taken_cnt", taken_cnt, m_cnt);
            chk("m_busy", busy, m_pend);
            chk("m_stall_out", stall_out, exp_stall);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input bit [2:0] op, input int a, input int b, input bit rsr,
                         input bit rtr, input bit [31:0] pc, input bit [15:0] im);
        valid_in = 1; br_op = op; rs_val = a; rt_val = b;
        rs_ready = rsr; rt_ready = rtr; pc_plus4 = pc; imm = im;
    endtask

    typedef struct { bit [2:0] op; int a; int b; bit tk; } vec_t;
    vec_t vecs[8] = '{
        '{3'b100, 0, 0, 1}, '{3'b110, -1, 0, 0}, '{3'b011, 7, 0, 1}, '{3'b001, 5, 6, 0},
        '{3'b010, 8, 8, 0}, '{3'b100, 1, 0, 0}, '{3'b101, 0, 0, 0}, '{3'b110, 0, 0, 1}
    };

    initial begin
        #2 reset = 1'b0;
        cmp_en = 1;
        #1;
        chk("rst_stall", stall_out, 0);
        chk("rst_target", target, 0);
        chk("rst_cnt", taken_cnt, 0);
        tick(); tick();
        reset = 1'b1;
        tick();

        // beq taken, immediate resolve
        issue(3'b001, 5, 5, 1, 1, 32'h3004, 16'h0004);
        #1 chk("beq_stall", stall_out, 0);
        tick();
        valid_in = 0;
        chk("beq_rv", resolve_valid, 1);
        chk("beq_taken", taken, 1);
        chk("beq_target", target, 32'h3014);
        chk("beq_cnt", taken_cnt, 1);
        tick();
        chk("hold_rv", resolve_valid, 0);
        chk("hold_target", target, 32'h3014);

        // bgtz on -1 ignores rt_ready
        issue(3'b011, -1, 0, 1, 0, 32'h40, 16'h0001);
        #1 chk("bgtz_stall", stall_out, 0);
        tick();
        valid_in = 0;
        chk("bgtz_rv", resolve_valid, 1);
        chk("bgtz_taken", taken, 0);

        // bne waits for rt, uses captured fields despite changed inputs
        issue(3'b010, 1, 2, 1, 0, 32'h1000, 16'h0010);
        for (int i = 0; i < 3; i++) begin
            #1 chk("bne_stall", stall_out, 1);
            tick();
            if (i == 0) begin
                valid_in = 0; br_op = 3'b011; pc_plus4 = 32'h5555; imm = 16'h7FFF;
            end
            chk("bne_busy", busy, 1);
        end
        rt_ready = 1;
        #1 chk("bne_ready_stall", stall_out, 0);
        tick();
        chk("bne_rv", resolve_valid, 1);
        chk("bne_taken", taken, 1);
        chk("bne_target", target, 32'h1040);
        chk("bne_busy_done", busy, 0);
        chk("bne_cnt", taken_cnt, 2);

        // bltz timeout after counter reaches MAX_WAIT
        issue(3'b101, -5, 0, 0, 1, 32'h80, 16'h0002);
        #1 chk("to_stall0", stall_out, 1);
        tick();
        valid_in = 0;
        for (int i = 0; i < 4; i++) begin
            chk("to_stall", stall_out, 1);
            chk("to_busy", busy, 1);
            chk("to_early", timeout_err, 0);
            tick();
        end
        chk("to_pulse", timeout_err, 1);
        chk("to_no_rv", resolve_valid, 0);
        chk("to_idle", busy, 0);
        tick();
        chk("to_single", timeout_err, 0);

        // ready in the same cycle the counter expires resolves instead
        issue(3'b101, -5, 0, 0, 0, 32'h80, 16'h0002);
        tick();
        valid_in = 0;
        repeat (3) tick();
        rs_ready = 1;
        #1 chk("race_stall", stall_out, 0);
        tick();
        chk("race_rv", resolve_valid, 1);
        chk("race_no_to", timeout_err, 0);
        chk("race_taken", taken, 1);

        // target wrap and counter saturation
        issue(3'b001, 0, 0, 1, 1, 32'h0000_0004, 16'h8000);
        tick();
        chk("wrap_target", target, 32'hFFFE_0004);
        chk("sat_cnt4", taken_cnt, 3);
        tick();
        valid_in = 0;
        chk("sat_cnt5", taken_cnt, 3);

        // condition table, back-to-back resolves
        foreach (vecs[i]) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 1, 1, 32'h2000, 16'hFFFE);
            tick();
            chk("tbl_rv", resolve_valid, 1);
            chk("tbl_taken", taken, vecs[i].tk);
            chk("tbl_target", target, 32'h1FF8);
        end
        valid_in = 0;

        // reserved/none opcodes are ignored
        issue(3'b000, 1, 1, 0, 0, 32'h10, 16'h1);
        #1 chk("op0_stall", stall_out, 0);
        tick();
        chk("op0_rv", resolve_valid, 0);
        br_op = 3'b111;
        #1 chk("op7_stall", stall_out, 0);
        tick();
        chk("op7_rv", resolve_valid, 0);
        chk("op7_busy", busy, 0);
        valid_in = 0;

        // flush during WAIT and flush over an immediate resolve
        issue(3'b010, 1, 2, 1, 0, 32'h900, 16'h3);
        tick();
        valid_in = 0;
        chk("fl_busy", busy, 1);
        flush = 1;
        #1 chk("fl_stall", stall_out, 0);
        tick();
        flush = 0;
        chk("fl_idle", busy, 0);
        chk("fl_rv", resolve_valid, 0);
        repeat (5) begin
            tick();
            chk("fl_after_to", timeout_err, 0);
            chk("fl_after_stall", stall_out, 0);
        end
        rt_ready = 1;
        tick();
        chk("fl_after_rv", resolve_valid, 0);
        issue(3'b001, 3, 3, 1, 1, 32'h700, 16'h1);
        flush = 1;
        tick();
        flush = 0; valid_in = 0;
        chk("fl_imm_rv", resolve_valid, 0);
        chk("fl_imm_cnt", taken_cnt, 3);

        // reset during WAIT discards the branch and clears the counter
        issue(3'b010, 1, 2, 1, 0, 32'h900, 16'h3);
        tick();
        valid_in = 0;
        tick();
        #2 reset = 1'b0;
        #1;
        chk("rw_stall", stall_out, 0);
        chk("rw_busy", busy, 0);
        chk("rw_cnt", taken_cnt, 0);
        chk("rw_target", target, 0);
        chk("rw_taken", taken, 0);
        tick();
        reset = 1'b1;
        repeat (5) begin
            tick();
            chk("rw_after_rv", resolve_valid, 0);
            chk("rw_after_to", timeout_err, 0);
        end
        rt_ready = 1;
        tick();
        chk("rw_late_rv", resolve_valid, 0);

        // counter counts again after reset; negative offset target
        issue(3'b001, 9, 9, 1, 1, 32'h100, 16'hFFFF);
        tick();
        valid_in = 0;
        chk("post_taken", taken, 1);
        chk("post_target", target, 32'h0000_00FC);
        chk("post_cnt", taken_cnt, 1);
        tick();

        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
